data_memory: RTL and testbench

- Word-addressed data memory front end for the core.
- A small direct-mapped write-through cache (write-allocate) sits between the core load/store port and a slower backing memory.
- The backing memory uses a request/response handshake; the bench backing model is temporary_memory.
- Hits complete locally. Misses and all writes go through the memory handshake, during which the block reports busy.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_cache_array.sv | 47 ++++
 rtl/data_memory.sv | 174 +++++++++++++++++
 tb/tb_data_memory.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the data_memory cache front end.
// Default widths match the core load/store port and the backing memory bus.
package dmem_pkg;

    localparam int DMEM_ADDR_W     = 8;
    localparam int DMEM_DATA_W     = 32;
    localparam int DMEM_MEM_ADDR_W = 32;
    localparam int DMEM_LINES      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    // One word per line, so the index is just the low address bits.
    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_bits(input int addr_w, input int lines);
        return addr_w - $clog2(lines);
    endfunction

endpackage

// File: rtl/dmem_cache_array.sv
// Direct-mapped valid/tag/data store: one synchronous write port, combinational lookup.
// Latency: lookup 0 cycles, write visible after the clock edge. No backpressure.
import dmem_pkg::*;

module dmem_cache_array #(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W,
    parameter int LINES  = DMEM_LINES,
    localparam int IDX_W = idx_bits(LINES),
    localparam int TAG_W = tag_bits(ADDR_W, LINES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  lk_idx_i,
    input  logic [TAG_W-1:0]  lk_tag_i,
    output logic              lk_hit_o,
    output logic [DATA_W-1:0] lk_data_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [DATA_W-1:0] wr_data_i
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    // Only the valid bits need reset; tag/data are qualified by them.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign lk_hit_o  = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);
    assign lk_data_o = data_q[lk_idx_i];

endmodule

// File: rtl/data_memory.sv
// Write-through, write-allocate direct-mapped cache in front of a req/resp backing memory.
// Latency: read hit 1 cycle, miss = memory latency + 1; busy holds off requests meanwhile.
// Optional hit/miss counters are enabled with `define DATA_MEMORY_STATS_EN.
import dmem_pkg::*;

module data_memory #(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int LINES      = DMEM_LINES,
    parameter int MEM_ADDR_W = DMEM_MEM_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     addr,
    output logic [DATA_W-1:0]     data_read,
    input  logic [DATA_W-1:0]     data_write,
    input  logic                  read_en,
    input  logic                  write_en,
    output logic                  busy,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    input  logic [DATA_W-1:0]     mem_read_val,
    output logic [DATA_W-1:0]     mem_write_val,
    input  logic                  mem_response
`ifdef DATA_MEMORY_STATS_EN
    ,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
`endif
);

    localparam int IDX_W = idx_bits(LINES);
    localparam int TAG_W = tag_bits(ADDR_W, LINES);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_read_q, data_read_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0] wval_q, wval_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;

    logic              lk_hit;
    logic [DATA_W-1:0] lk_data;
    logic              cache_we;
    logic [IDX_W-1:0]  cache_widx;
    logic [TAG_W-1:0]  cache_wtag;
    logic [DATA_W-1:0] cache_wdata;

    dmem_cache_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LINES  (LINES)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .lk_idx_i  (addr[IDX_W-1:0]),
        .lk_tag_i  (addr[ADDR_W-1:IDX_W]),
        .lk_hit_o  (lk_hit),
        .lk_data_o (lk_data),
        .wr_en_i   (cache_we && !reset),
        .wr_idx_i  (cache_widx),
        .wr_tag_i  (cache_wtag),
        .wr_data_i (cache_wdata)
    );

    always_comb begin
        state_d     = state_q;
        data_read_d = data_read_q;
        lat_addr_d  = lat_addr_q;
        wval_d      = wval_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        cache_we    = 1'b0;
        cache_widx  = addr[IDX_W-1:0];
        cache_wtag  = addr[ADDR_W-1:IDX_W];
        cache_wdata = data_write;

        case (state_q)
            IDLE: begin
                // Write takes priority; a simultaneous read is dropped.
                if (write_en) begin
                    cache_we   = 1'b1;
                    lat_addr_d = addr;
                    wval_d     = data_write;
                    mem_wr_d   = 1'b1;
                    state_d    = WRITE;
                end else if (read_en) begin
                    if (lk_hit) begin
                        data_read_d = lk_data;
                    end else begin
                        lat_addr_d = addr;
                        mem_rd_d   = 1'b1;
                        state_d    = READ;
                    end
                end
            end
            WRITE: begin
                if (mem_response) begin
                    mem_wr_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            READ: begin
                // Fill uses the address latched at request time, not the live core input.
                if (mem_response) begin
                    data_read_d = mem_read_val;
                    cache_we    = 1'b1;
                    cache_widx  = lat_addr_q[IDX_W-1:0];
                    cache_wtag  = lat_addr_q[ADDR_W-1:IDX_W];
                    cache_wdata = mem_read_val;
                    mem_rd_d    = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            data_read_q <= '0;
            lat_addr_q  <= '0;
            wval_q      <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_read_q <= data_read_d;
            lat_addr_q  <= lat_addr_d;
            wval_q      <= wval_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
        end
    end

    assign data_read     = data_read_q;
    assign busy          = (state_q != IDLE);
    assign mem_addr      = MEM_ADDR_W'(lat_addr_q);
    assign mem_write_val = wval_q;
    assign mem_read_en   = mem_rd_q;
    assign mem_write_en  = mem_wr_q;

`ifdef DATA_MEMORY_STATS_EN
    logic        rd_accept;
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    assign rd_accept = (state_q == IDLE) && read_en && !write_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rd_accept) begin
            if (lk_hit && hit_cnt_q != 16'hFFFF) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (!lk_hit && miss_cnt_q != 16'hFFFF) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed vector table, reset/priority corner cases,
// then random traffic against an address-level reference model of memory and cache contents.
module tb_data_memory;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 32;
    localparam int LINES      = 8;
    localparam int MEM_ADDR_W = 32;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     data_read;
    logic [DATA_W-1:0]     data_write;
    logic                  read_en;
    logic                  write_en;
    logic                  busy;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic                  mem_read_en;
    logic                  mem_write_en;
    logic [DATA_W-1:0]     mem_read_val;
    logic [DATA_W-1:0]     mem_write_val;
    logic                  mem_response;
`ifdef DATA_MEMORY_STATS_EN
    logic [15:0]           hit_count;
    logic [15:0]           miss_count;
    int                    exp_hits;
    int                    exp_misses;
`endif

    always #5 clk = ~clk;

    data_memory #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LINES      (LINES),
        .MEM_ADDR_W (MEM_ADDR_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .addr          (addr),
        .data_read     (data_read),
        .data_write    (data_write),
        .read_en       (read_en),
        .write_en      (write_en),
        .busy          (busy),
        .mem_addr      (mem_addr),
        .mem_read_en   (mem_read_en),
        .mem_write_en  (mem_write_en),
        .mem_read_val  (mem_read_val),
        .mem_write_val (mem_write_val),
        .mem_response  (mem_response)
`ifdef DATA_MEMORY_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hA500_0000 + 32'(i) * 32'h0001_0001;
    endfunction

    // temporary_memory: responds one cycle after seeing a request, never back-to-back.
    logic [DATA_W-1:0] bmem [256];
    initial begin
        for (int i = 0; i < 256; i++) bmem[i] <= init_word(i);
        mem_response <= 1'b0;
        mem_read_val <= '0;
    end
    always @(posedge clk) begin
        if (mem_response) begin
            mem_response <= 1'b0;
        end else if (mem_read_en || mem_write_en) begin
            mem_response <= 1'b1;
            if (mem_write_en) bmem[mem_addr[7:0]] <= mem_write_val;
            else              mem_read_val <= bmem[mem_addr[7:0]];
        end
    end

    // Reference model: memory contents plus which address each line currently holds.
    logic [DATA_W-1:0] ref_mem [256];
    bit                line_vld  [LINES];
    logic [ADDR_W-1:0] line_addr [LINES];
    logic [DATA_W-1:0] exp_dr;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) line_vld[i] = 1'b0;
        exp_dr = '0;
`ifdef DATA_MEMORY_STATS_EN
        exp_hits   = 0;
        exp_misses = 0;
`endif
    endtask

    function automatic bit model_hit(input logic [ADDR_W-1:0] a);
        int li;
        li = int'(a) % LINES;
        return line_vld[li] && (line_addr[li] == a);
    endfunction

    task automatic model_fill(input logic [ADDR_W-1:0] a);
        line_vld[int'(a) % LINES]  = 1'b1;
        line_addr[int'(a) % LINES] = a;
    endtask

    // Wait for busy to fall, scrambling the core inputs to prove the latched values are used.
    task automatic wait_idle(input string name, output int cycles);
        cycles = 0;
        while (busy && cycles < 20) begin
            @(negedge clk);
            addr       = ADDR_W'($urandom);
            data_write = $urandom;
            @(posedge clk);
            #1;
            cycles++;
        end
        chk(name, 64'(busy), 64'd0);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input bit also_read);
        int n;
        @(negedge clk);
        addr = a; data_write = d; write_en = 1'b1; read_en = also_read;
        @(posedge clk);
        #1;
        write_en = 1'b0; read_en = 1'b0;
        chk("wr_busy", 64'(busy), 64'd1);
        chk("wr_mem_write_en", 64'(mem_write_en), 64'd1);
        chk("wr_mem_read_en", 64'(mem_read_en), 64'd0);
        chk("wr_mem_addr", 64'(mem_addr), 64'(a));
        chk("wr_mem_write_val", 64'(mem_write_val), 64'(d));
        ref_mem[a] = d;
        model_fill(a);
        wait_idle("wr_done", n);
        chk("wr_mem_write_en_drop", 64'(mem_write_en), 64'd0);
        chk("wr_data_read_held", 64'(data_read), 64'(exp_dr));
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input bit exp_hit,
                           input logic [DATA_W-1:0] exp_d);
        int n;
        @(negedge clk);
        addr = a; read_en = 1'b1; write_en = 1'b0;
        @(posedge clk);
        #1;
        read_en = 1'b0;
`ifdef DATA_MEMORY_STATS_EN
        if (exp_hit) exp_hits++; else exp_misses++;
`endif
        if (exp_hit) begin
            chk("rd_hit_busy", 64'(busy), 64'd0);
            chk("rd_hit_mem_read_en", 64'(mem_read_en), 64'd0);
        end else begin
            chk("rd_miss_busy", 64'(busy), 64'd1);
            chk("rd_miss_mem_read_en", 64'(mem_read_en), 64'd1);
            chk("rd_miss_mem_addr", 64'(mem_addr), 64'(a));
            wait_idle("rd_miss_done", n);
            chk("rd_miss_latency", 64'(n), 64'd2);
            chk("rd_miss_mem_read_en_drop", 64'(mem_read_en), 64'd0);
            model_fill(a);
        end
        exp_dr = exp_d;
        chk("rd_data", 64'(data_read), 64'(exp_d));
    endtask

    typedef struct {
        bit                wr;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        bit                exp_hit;
        logic [DATA_W-1:0] exp_d;
    } vec_t;

    vec_t tbl[$];

    initial begin
        reset = 1'b1; addr = '0; data_write = '0; read_en = 1'b0; write_en = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        model_reset();

        tbl.push_back('{1'b0, 8'd3, 32'd0, 1'b0, 32'hA503_0003});
        for (int i = 0; i < 8; i++) tbl.push_back('{1'b1, 8'(i), 32'(i + 1), 1'b0, 32'd0});
        for (int i = 0; i < 8; i++) tbl.push_back('{1'b0, 8'(i), 32'd0, 1'b1, 32'(i + 1)});
        tbl.push_back('{1'b1, 8'd2,  32'hAA, 1'b0, 32'd0});
        tbl.push_back('{1'b1, 8'd10, 32'hBB, 1'b0, 32'd0});
        tbl.push_back('{1'b0, 8'd2,  32'd0, 1'b0, 32'hAA});
        tbl.push_back('{1'b0, 8'd10, 32'd0, 1'b0, 32'hBB});
        tbl.push_back('{1'b0, 8'd10, 32'd0, 1'b1, 32'hBB});

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mem_read_en", 64'(mem_read_en), 64'd0);
        chk("rst_mem_write_en", 64'(mem_write_en), 64'd0);
        chk("rst_data_read", 64'(data_read), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_write_val", 64'(mem_write_val), 64'd0);

        foreach (tbl[i]) begin
            if (tbl[i].wr) do_write(tbl[i].a, tbl[i].d, 1'b0);
            else           do_read(tbl[i].a, tbl[i].exp_hit, tbl[i].exp_d);
        end

        // Both enables: write wins, read dropped; then the written word hits.
        do_write(8'd5, 32'h55, 1'b1);
        do_read(8'd5, 1'b1, 32'h55);

        // Reset during a miss aborts it; the line is not filled.
        @(negedge clk);
        addr = 8'd20; read_en = 1'b1;
        @(posedge clk);
        #1;
        read_en = 1'b0;
        chk("rstmid_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_mem_read_en", 64'(mem_read_en), 64'd0);
        chk("rstmid_data_read", 64'(data_read), 64'd0);
        do_read(8'd20, 1'b0, init_word(20));

        for (int k = 0; k < 80; k++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0) do_write(a, $urandom, 1'($urandom_range(0, 1)));
            else                           do_read(a, model_hit(a), ref_mem[a]);
        end

`ifdef DATA_MEMORY_STATS_EN
        @(negedge clk);
        chk("stats_hits", 64'(hit_count), 64'(exp_hits));
        chk("stats_misses", 64'(miss_count), 64'(exp_misses));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk("stats_rst_hits", 64'(hit_count), 64'd0);
        chk("stats_rst_misses", 64'(miss_count), 64'd0);
        do_read(8'd7, 1'b0, ref_mem[7]);
        for (int i = 0; i < 3; i++) do_read(8'd7, 1'b1, ref_mem[7]);
        chk("stats_hits_3", 64'(hit_count), 64'd3);
        chk("stats_misses_1", 64'(miss_count), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
